output_ctrl: RTL and testbench
==============================

# output_ctrl

Output-port controller of the router, directly downstream of the input controllers. It collects per-input channel requests and arbitrates among them round-robin. The winning 64-bit flit is captured into one of two single-entry virtual-channel buffers (even/odd), selected by the global polarity, and driven onto the outbound link to the next router's input controller under a send/receive handshake.

## Interface
Parameters:
- NUM_IN, 4, number of input controllers competing for this output
- DATA_WIDTH, 64, flit width

Ports:
- clk  input  1  router clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-low
- polarity  input  1  global phase: 0 = even phase, 1 = odd phase
- req  input  NUM_IN  request from input controller i; flit valid on data_in slice i
- data_in  input  NUM_IN*DATA_WIDTH  flits; slice i = data_in[i*DATA_WIDTH +: DATA_WIDTH]
- grant  output  NUM_IN  one-hot or zero; returned to input controller i as its channel-clean signal
- receiveO  input  1  downstream input controller can accept a flit this cycle
- sendO  output  1  flit on dataO is transferred at this clock edge
- dataO  output  DATA_WIDTH  outbound flit

## Operation
- State: even_vc and odd_vc, each holding one flit plus a full flag. Round-robin pointer rr_ptr is log2(NUM_IN) bits.
- Router-side write VC: even_vc when polarity=0, odd_vc when polarity=1.
- Link-side send VC: the opposite VC. A VC is never read and written in the same cycle.
- Arbitration (combinational):
  - grant is all-zero if the write VC is full.
  - Otherwise grant selects the first requesting index at or after rr_ptr, wrapping modulo NUM_IN.
  - grant is all-zero if req is all-zero.
  - At most one grant bit is set.
- Write: on an edge with grant[k]=1, the write VC captures slice k and sets full. rr_ptr ← (k+1) mod NUM_IN.
- rr_ptr is unchanged when no grant is issued.
- Send:
  - sendO = send-VC full AND receiveO.
  - dataO = send-VC data whenever the send VC is full, else 0.
  - On an edge with sendO=1, the send VC's full flag clears.
- Simultaneous events: a grant into one VC and a send from the other VC in the same cycle are both performed.
- Polarity held constant across cycles (stall): the same VC roles persist, with no loss or duplication.
- Reset (asserted at any time, including mid-transfer):
  - Immediately clears both full flags, both data registers (to 0) and rr_ptr (to 0).
  - Resulting outputs: grant=0, sendO=0, dataO=0.
  - An in-flight flit is discarded.
  - Deassertion is synchronised externally. The first active edge after release behaves as a normal cycle.

## Timing
- grant, sendO and dataO are combinational from registered state and current inputs (req, polarity, receiveO). There is no registered output.
- Input controller handshake:
  - req sampled and grant returned in the same cycle.
  - The flit is consumed at the edge closing that cycle.
  - The requester must hold data valid through that edge.
- Minimum latency: flit granted in cycle t (phase P); sendO can assert in cycle t+1 (phase !P) if receiveO=1.
- Throughput: one flit per cycle sustained when polarity toggles every cycle and receiveO stays high. Each VC alternates write and send.
- receiveO low: the send VC stays full. Its next write opportunity is then blocked (grant=0), applying backpressure.

## Structure
- Shared package router_pkg:
  - DATA_WIDTH and NUM_IN defaults
  - polarity encodings POL_EVEN=0 and POL_ODD=1
  - flit typedef of DATA_WIDTH bits
- Sub-module rr_arbiter, parameterised on NUM_IN:
  - inputs: req, enable, pointer
  - outputs: one-hot grant and next pointer
- output_ctrl instantiates rr_arbiter and contains the two VC registers and the send mux inline.

## Test plan
- Reset mid-operation: both VCs full, rst driven low between edges -> grant=0, sendO=0 and dataO=0 immediately (before the next edge); after release, req=4'b0001 with polarity=0 -> grant=4'b0001.
- Single flit: polarity=0, req=4'b0100, slice 2 = 64'hA5A5_0000_0000_0002, receiveO=1 -> grant=4'b0100 in cycle t; in cycle t+1 (polarity=1) sendO=1 and dataO=64'hA5A5_0000_0000_0002; sendO=0 in t+2.
- Round-robin fairness: req=4'b1111 held, polarity toggling, receiveO=1 -> grant sequence 0001, 0010, 0100, 1000, 0001; dataO carries slices in the same order, one cycle delayed.
- Wrap-around: rr_ptr=3, req=4'b0011 -> grant=4'b0001; rr_ptr becomes 1.
- Backpressure: receiveO=0 for 3 cycles with both VCs filled -> sendO=0 and grant=0 while both VCs are full; contents are retained. After receiveO=1, flits leave in original order with no duplication.
- Stall: polarity held at 1 for 3 cycles, req=4'b0001, receiveO=1 -> only odd_vc is written and only even_vc is sent; grant is issued each cycle odd_vc is empty.

Source files
------------

// File: rtl/router_pkg.sv
// Shared router definitions: default geometry, polarity encodings and flit type.
package router_pkg;

    localparam int unsigned DATA_WIDTH = 64;
    localparam int unsigned NUM_IN     = 4;

    localparam logic POL_EVEN = 1'b0;
    localparam logic POL_ODD  = 1'b1;

    typedef logic [DATA_WIDTH-1:0] flit_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// wrapping, and reports the pointer value that follows the winner.
module rr_arbiter #(
    parameter int unsigned NUM_IN = 4,
    parameter int unsigned PTR_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic [NUM_IN-1:0] req,
    input  logic              enable,
    input  logic [PTR_W-1:0]  pointer,
    output logic [NUM_IN-1:0] grant_c,
    output logic [PTR_W-1:0]  next_ptr_c
);

    logic found;

    // Scan NUM_IN positions starting at the pointer; the first hit wins.
    always_comb begin
        grant_c    = '0;
        next_ptr_c = pointer;
        found      = 1'b0;
        for (int unsigned ofs = 0; ofs < NUM_IN; ofs++) begin
            int unsigned       idx;
            logic [PTR_W-1:0]  sel;
            idx = (32'(pointer) + ofs) % NUM_IN;
            sel = PTR_W'(idx);
            if (enable && !found && req[sel]) begin
                grant_c[sel] = 1'b1;
                next_ptr_c   = PTR_W'((idx + 1) % NUM_IN);
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/output_ctrl.sv
// Router output port: round-robin arbitration into even/odd single-flit VCs,
// with the VC opposite the current polarity draining onto the outbound link.
module output_ctrl #(
    parameter int unsigned NUM_IN     = router_pkg::NUM_IN,
    parameter int unsigned DATA_WIDTH = router_pkg::DATA_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         polarity,
    input  logic [NUM_IN-1:0]            req,
    input  logic [NUM_IN*DATA_WIDTH-1:0] data_in,
    output logic [NUM_IN-1:0]            grant,
    input  logic                         receiveO,
    output logic                         sendO,
    output logic [DATA_WIDTH-1:0]        dataO
);

    import router_pkg::*;

    localparam int unsigned PTR_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    logic                  even_full_q, even_full_d;
    logic                  odd_full_q,  odd_full_d;
    logic [DATA_WIDTH-1:0] even_data_q, even_data_d;
    logic [DATA_WIDTH-1:0] odd_data_q,  odd_data_d;
    logic [PTR_W-1:0]      rr_ptr_q,    rr_ptr_d;

    logic                  wr_is_odd;
    logic                  wr_full;
    logic                  arb_en;
    logic                  grant_any;
    logic [PTR_W-1:0]      arb_next_ptr;
    logic [DATA_WIDTH-1:0] win_data;
    logic                  send_full;
    logic [DATA_WIDTH-1:0] send_data;

    assign wr_is_odd = (polarity == POL_ODD);
    assign wr_full   = wr_is_odd ? odd_full_q : even_full_q;
    // Holding off grants while rst is low keeps grant at zero during reset.
    assign arb_en    = rst && !wr_full;

    rr_arbiter #(
        .NUM_IN (NUM_IN),
        .PTR_W  (PTR_W)
    ) u_arb (
        .req        (req),
        .enable     (arb_en),
        .pointer    (rr_ptr_q),
        .grant_c    (grant),
        .next_ptr_c (arb_next_ptr)
    );

    assign grant_any = |grant;

    // Grant is one-hot, so an AND-OR mux selects the winning slice.
    always_comb begin
        win_data = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            win_data = win_data
                     | (data_in[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{grant[i]}});
        end
    end

    assign send_full = wr_is_odd ? even_full_q : odd_full_q;
    assign send_data = wr_is_odd ? even_data_q : odd_data_q;
    assign sendO     = send_full && receiveO;
    assign dataO     = send_full ? send_data : '0;

    // Write VC and send VC are always distinct, so both updates can coexist.
    always_comb begin
        even_full_d = even_full_q;
        odd_full_d  = odd_full_q;
        even_data_d = even_data_q;
        odd_data_d  = odd_data_q;
        rr_ptr_d    = rr_ptr_q;
        if (grant_any) begin
            rr_ptr_d = arb_next_ptr;
            if (wr_is_odd) begin
                odd_full_d = 1'b1;
                odd_data_d = win_data;
            end else begin
                even_full_d = 1'b1;
                even_data_d = win_data;
            end
        end
        if (sendO) begin
            if (wr_is_odd) begin
                even_full_d = 1'b0;
            end else begin
                odd_full_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            even_full_q <= 1'b0;
            odd_full_q  <= 1'b0;
            even_data_q <= '0;
            odd_data_q  <= '0;
            rr_ptr_q    <= '0;
        end else begin
            even_full_q <= even_full_d;
            odd_full_q  <= odd_full_d;
            even_data_q <= even_data_d;
            odd_data_q  <= odd_data_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

endmodule

// File: tb/tb_output_ctrl.sv
// Directed bench for output_ctrl: vector table plus hand-written sequences
// for backpressure, polarity stall and asynchronous reset mid-transfer.
module tb_output_ctrl;

    localparam int unsigned NI = 4;
    localparam int unsigned DW = 64;

    localparam logic [63:0] S0 = 64'hA5A5_0000_0000_0000;
    localparam logic [63:0] S1 = 64'hA5A5_0000_0000_0001;
    localparam logic [63:0] S2 = 64'hA5A5_0000_0000_0002;
    localparam logic [63:0] S3 = 64'hA5A5_0000_0000_0003;

    logic              clk;
    logic              rst;
    logic              polarity;
    logic [NI-1:0]     req;
    logic [NI*DW-1:0]  data_in;
    logic [NI-1:0]     grant;
    logic              receiveO;
    logic              sendO;
    logic [DW-1:0]     dataO;

    int total;
    int bad;

    typedef struct {
        logic          pol;
        logic [NI-1:0] req;
        logic          recv;
        logic [NI-1:0] exp_grant;
        logic          exp_send;
        logic [DW-1:0] exp_data;
    } vec_t;

    vec_t tbl [12];

    output_ctrl #(.NUM_IN(NI), .DATA_WIDTH(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .polarity (polarity),
        .req      (req),
        .data_in  (data_in),
        .grant    (grant),
        .receiveO (receiveO),
        .sendO    (sendO),
        .dataO    (dataO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check_outs(input string nm, input logic [NI-1:0] eg,
                              input logic es, input logic [DW-1:0] ed);
        total++;
        if (grant !== eg) begin
            bad++;
            $display("FAIL %s grant: got %b want %b", nm, grant, eg);
        end
        total++;
        if (sendO !== es) begin
            bad++;
            $display("FAIL %s sendO: got %b want %b", nm, sendO, es);
        end
        total++;
        if (dataO !== ed) begin
            bad++;
            $display("FAIL %s dataO: got %h want %h", nm, dataO, ed);
        end
    endtask

    // Called at posedge+1: drive, check at negedge, then pass the next posedge.
    task automatic step(input string nm, input logic pol, input logic [NI-1:0] rq,
                        input logic rv, input logic [NI-1:0] eg, input logic es,
                        input logic [DW-1:0] ed);
        polarity = pol;
        req      = rq;
        receiveO = rv;
        @(negedge clk);
        check_outs(nm, eg, es, ed);
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < int'(NI); i++) begin
            data_in[i*DW +: DW] = S0 + 64'(i);
        end

        // round-robin from pointer 0 with polarity toggling
        tbl[0]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b0, 64'h0};
        tbl[1]  = '{1'b1, 4'b1111, 1'b1, 4'b0010, 1'b1, S0};
        tbl[2]  = '{1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, S1};
        tbl[3]  = '{1'b1, 4'b1111, 1'b1, 4'b1000, 1'b1, S2};
        tbl[4]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, S3};
        tbl[5]  = '{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b1, S0};
        // single flit from slice 2
        tbl[6]  = '{1'b0, 4'b0100, 1'b1, 4'b0100, 1'b0, 64'h0};
        tbl[7]  = '{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b1, S2};
        tbl[8]  = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 64'h0};
        // wrap-around from pointer 3
        tbl[9]  = '{1'b1, 4'b0011, 1'b1, 4'b0001, 1'b0, 64'h0};
        tbl[10] = '{1'b0, 4'b0011, 1'b1, 4'b0010, 1'b1, S0};
        tbl[11] = '{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b1, S1};

        rst      = 1'b0;
        polarity = 1'b0;
        req      = 4'b1111;
        receiveO = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outs("reset_state", 4'b0000, 1'b0, 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        for (int v = 0; v < 12; v++) begin
            step($sformatf("vec%0d", v), tbl[v].pol, tbl[v].req, tbl[v].recv,
                 tbl[v].exp_grant, tbl[v].exp_send, tbl[v].exp_data);
        end

        // backpressure: fill both VCs, hold receiveO low, then drain in order
        step("bp_fill_even", 1'b0, 4'b0100, 1'b0, 4'b0100, 1'b0, 64'h0);
        step("bp_fill_odd",  1'b1, 4'b1000, 1'b0, 4'b1000, 1'b0, S2);
        step("bp_hold0",     1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0, S3);
        step("bp_hold1",     1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0, S2);
        step("bp_hold2",     1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0, S3);
        step("bp_drain0",    1'b1, 4'b0000, 1'b1, 4'b0000, 1'b1, S2);
        step("bp_drain1",    1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, S3);
        step("bp_empty",     1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 64'h0);

        // stall: polarity held odd, even VC drains once, odd VC fills once
        step("st_prefill",   1'b0, 4'b0001, 1'b1, 4'b0001, 1'b0, 64'h0);
        step("st_cycle1",    1'b1, 4'b0001, 1'b1, 4'b0001, 1'b1, S0);
        step("st_cycle2",    1'b1, 4'b0001, 1'b1, 4'b0000, 1'b0, 64'h0);
        step("st_cycle3",    1'b1, 4'b0001, 1'b1, 4'b0000, 1'b0, 64'h0);
        step("st_release",   1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, S0);
        step("st_empty",     1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 64'h0);

        // reset mid-operation with both VCs full
        step("rs_fill_even", 1'b0, 4'b0001, 1'b1, 4'b0001, 1'b0, 64'h0);
        step("rs_fill_odd",  1'b1, 4'b0010, 1'b0, 4'b0010, 1'b0, S0);
        polarity = 1'b1;
        req      = 4'b1111;
        receiveO = 1'b1;
        #1;
        check_outs("rs_before", 4'b0000, 1'b1, S0);
        #1;
        rst = 1'b0;
        #1;
        check_outs("rs_asserted", 4'b0000, 1'b0, 64'h0);
        @(posedge clk);
        #1;
        check_outs("rs_held", 4'b0000, 1'b0, 64'h0);
        @(negedge clk);
        rst = 1'b1;
        req = 4'b0000;
        @(posedge clk);
        #1;
        step("rs_after", 1'b0, 4'b0001, 1'b1, 4'b0001, 1'b0, 64'h0);
        step("rs_after_send", 1'b1, 4'b0000, 1'b1, 4'b0000, 1'b1, S0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
